// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Owns the single command port of a synchronous framebuffer RAM. Display
// scan-out reads always win the slot; writer requests queue in a small FIFO
// and drain into slots the display leaves idle. All memory commands and
// display return data are registered.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 6,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 800
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // display read side
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_rvalid,
  output logic [DATA_W-1:0]             disp_rdata,
  // pixel writer side
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  // framebuffer RAM command port
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  // status
  output logic                          wr_starved,
  output logic [$clog2(WFIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(WFIFO_DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  // What the RAM port is used for in the current cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  slot_e slot;

  // write FIFO bookkeeping
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;

  logic [WFIFO_DEPTH-1:0][ENT_W-1:0] slot_vec;
  logic [WFIFO_DEPTH-1:0]            slot_load;

  // registered RAM command
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // read-return pipeline: stage 1 = command on the port, stage 2 = data on mem_rdata
  logic              rd_v1_q, rd_v1_d;
  logic              rd_v2_q, rd_v2_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // starvation tracking
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              starved_q, starved_d;

  assign fifo_empty = (level_q == '0);
  assign wr_ready   = (level_q != DEPTH_C);
  assign push       = wr_valid && wr_ready;
  assign head       = slot_vec[rd_ptr_q];

  // FIFO storage: one register per entry, loaded when the write pointer
  // selects it. Contents are only meaningful while counted in level_q, so
  // the storage itself needs no reset.
  for (genvar gi = 0; gi < WFIFO_DEPTH; gi++) begin : g_slot
    logic [ENT_W-1:0] entry_q, entry_d;

    assign slot_load[gi] = push && (wr_ptr_q == PTR_W'(gi));
    assign slot_vec[gi]  = entry_q;

    // capture the incoming request when this entry is the push target
    always_comb begin
      entry_d = entry_q;
      if (slot_load[gi]) begin
        entry_d = {wr_addr, wr_data};
      end
    end

    // entry storage register
    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end
  end

  // slot arbitration: display first, then a queued write, else idle
  always_comb begin
    slot = SLOT_IDLE;
    if (disp_req) begin
      slot = SLOT_READ;
    end else if (!fifo_empty) begin
      slot = SLOT_WRITE;
    end
  end

  assign pop = (slot == SLOT_WRITE);

  // FIFO pointer and occupancy update; push+pop leaves the level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // next RAM command; an idle slot keeps address and data stable
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (slot)
      SLOT_READ: begin
        mem_en_d   = 1'b1;
        mem_addr_d = disp_addr;
      end
      SLOT_WRITE: begin
        mem_en_d                  = 1'b1;
        mem_we_d                  = 1'b1;
        {mem_addr_d, mem_wdata_d} = head;
      end
      default: begin
        mem_en_d = 1'b0;
      end
    endcase
  end

  // read-return pipeline; returned pixel is captured only for real reads
  always_comb begin
    rd_v1_d  = (slot == SLOT_READ);
    rd_v2_d  = rd_v1_q;
    rvalid_d = rd_v2_q;
    rdata_d  = rdata_q;
    if (rd_v2_q) begin
      rdata_d = mem_rdata;
    end
  end

  // starvation counter: counts reads that beat a waiting write, any pop clears it
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if ((slot == SLOT_READ) && !fifo_empty && (starve_cnt_q != LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    starved_d = (starve_cnt_d == LIMIT_C);
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // RAM command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // read-return registers; reset drops reads that are still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q  <= 1'b0;
      rd_v2_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_v1_q  <= rd_v1_d;
      rd_v2_q  <= rd_v2_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // starvation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      starved_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = rdata_q;
  assign wr_starved  = starved_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a queue-based
// reference model and a behavioural RAM attached to the command port.
module tb_vga_fb_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          wr_starved;
  logic [2:0]    fifo_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_starved(wr_starved), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural synchronous RAM (low 10 address bits)
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; bit known; logic [DW-1:0] data; } rd_t;

  wr_t           wq[$];
  rd_t           pend[$];
  logic [DW-1:0] mm [1024];
  bit            mm_known [1024];
  logic          m_en, m_we, m_starved;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_cnt;

  // snapshot of the DUT outputs at the last step's sample point
  logic          o_en, o_we, o_rv, o_rdy, o_st;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_rd;
  logic [2:0]    o_lvl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    pend.delete();
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_cnt = 0; m_starved = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model,
  // then advance the model by the arbitration rules. Called just after a
  // rising edge; returns just after the next one.
  task automatic step(input logic dr, input logic [AW-1:0] da, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit            exp_rv, rd_mask;
    logic [DW-1:0] exp_rd;
    int            sz;
    wr_t           e;
    disp_req = dr; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    o_en = mem_en; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
    o_rv = disp_rvalid; o_rd = disp_rdata; o_lvl = fifo_level; o_rdy = wr_ready;
    o_st = wr_starved;
    exp_rv  = (pend.size() > 0) && (pend[0].due == cyc);
    rd_mask = exp_rv && pend[0].known;
    exp_rd  = rd_mask ? pend[0].data : '0;
    sz = wq.size();
    check($sformatf("model@%0d", cyc),
          64'({mem_en, mem_we, mem_addr, m_we ? mem_wdata : 6'd0, wr_starved,
               disp_rvalid, rd_mask ? disp_rdata : 6'd0, fifo_level, wr_ready}),
          64'({m_en, m_we, m_addr, m_we ? m_wdata : 6'd0, m_starved,
               exp_rv, exp_rd, 3'(sz), sz < DEPTH}));
    if (exp_rv) begin
      $display("RD  cyc=%0d data=%b", cyc, disp_rdata);
      void'(pend.pop_front());
    end
    // arbitration outcome for this cycle
    if (dr) begin
      m_en = 1'b1; m_we = 1'b0; m_addr = da;
      pend.push_back('{cyc + 3, mm_known[da[9:0]], mm[da[9:0]]});
      if (sz > 0 && m_cnt < LIMIT) m_cnt++;
    end else if (sz > 0) begin
      e = wq.pop_front();
      m_en = 1'b1; m_we = 1'b1; m_addr = e.addr; m_wdata = e.data;
      mm[e.addr[9:0]] = e.data;
      mm_known[e.addr[9:0]] = 1'b1;
      m_cnt = 0;
      $display("WR  cyc=%0d addr=%0d data=%b", cyc, e.addr, e.data);
    end else begin
      m_en = 1'b0; m_we = 1'b0;
    end
    if (wv && sz < DEPTH) wq.push_back('{wa, wd});
    m_starved = (m_cnt == LIMIT);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic dr; logic [AW-1:0] da; logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic e_en; logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata;
    logic e_rv; logic [DW-1:0] e_rd; logic [2:0] e_lvl; logic e_rdy;
  } vec_t;

  function automatic vec_t mk(logic dr, logic [AW-1:0] da, logic wv, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, logic en, logic we, logic [AW-1:0] ad,
                              logic [DW-1:0] wdat, logic rv, logic [DW-1:0] rd,
                              logic [2:0] lvl, logic rdy);
    vec_t v;
    v.dr = dr; v.da = da; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_wdata = wdat;
    v.e_rv = rv; v.e_rd = rd; v.e_lvl = lvl; v.e_rdy = rdy;
    return v;
  endfunction

  initial begin
    vec_t tbl[12];
    int   pushes, wes, rv_seen;
    logic st_log [16];

    // blanking drain of addr 0..3 / data 1..4, then addr 5 = red, then a read of 5
    tbl[0]  = mk(0, 0, 1, 0, 1,         0, 0, 0, 0,         0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 1, 1, 2,         0, 0, 0, 0,         0, 0, 1, 1);
    tbl[2]  = mk(0, 0, 1, 2, 3,         1, 1, 0, 1,         0, 0, 1, 1);
    tbl[3]  = mk(0, 0, 1, 3, 4,         1, 1, 1, 2,         0, 0, 1, 1);
    tbl[4]  = mk(0, 0, 1, 5, 6'b110000, 1, 1, 2, 3,         0, 0, 1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0,         1, 1, 3, 4,         0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,         1, 1, 5, 6'b110000, 0, 0, 0, 1);
    tbl[7]  = mk(1, 5, 0, 0, 0,         0, 0, 5, 0,         0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0,         1, 0, 5, 0,         0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0,         0, 0, 5, 0,         0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0,         0, 0, 5, 0,         1, 6'b110000, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0,         0, 0, 5, 0,         0, 0, 0, 1);

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por_outputs", 64'({mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata, wr_starved}), 64'd0);
    check("por_ready_level", 64'({wr_ready, fifo_level}), 64'({1'b1, 3'd0}));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].dr, tbl[i].da, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      $display("VEC %0d dr=%b wv=%b en=%b we=%b addr=%0d lvl=%0d rdy=%b rv=%b",
               i, tbl[i].dr, tbl[i].wv, o_en, o_we, o_addr, o_lvl, o_rdy, o_rv);
      check($sformatf("vec%0d", i),
            64'({o_en, o_we, o_addr, tbl[i].e_we ? o_wdata : 6'd0, o_rv,
                 tbl[i].e_rv ? o_rd : 6'd0, o_lvl, o_rdy}),
            64'({tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_we ? tbl[i].e_wdata : 6'd0,
                 tbl[i].e_rv, tbl[i].e_rv ? tbl[i].e_rd : 6'd0, tbl[i].e_lvl, tbl[i].e_rdy}));
    end

    // priority and backpressure: 640 cycles of display reads with the writer pushing
    pushes = 0; wes = 0;
    for (int i = 0; i < 640; i++) begin
      step(1'b1, 19'(i), 1'b1, 19'(200 + i), 6'(i));
      if (o_rdy) pushes++;
      if (o_we) wes++;
    end
    check("prio_pushes", 64'(pushes), 64'd4);
    check("prio_no_write", 64'(wes), 64'd0);
    check("prio_ready_low", 64'(o_rdy), 64'd0);
    check("prio_starved", 64'(o_st), 64'd1);
    step(1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    check("prio_first_write", 64'({o_we, o_addr, o_wdata}), 64'({1'b1, 19'd200, 6'd0}));
    check("prio_ready_back", 64'({o_rdy, o_lvl}), 64'({1'b1, 3'd3}));
    repeat (5) step(1'b0, 0, 1'b0, 0, 0);

    // starvation: one queued write, display holds the slot for 12 cycles
    for (int s = 0; s < 16; s++) begin
      step(s < 12, 19'(s), s == 0, 19'd300, 6'd7);
      st_log[s] = o_st;
    end
    check("starve_before", 64'(st_log[8]), 64'd0);
    check("starve_rise", 64'(st_log[9]), 64'd1);
    check("starve_held", 64'(st_log[12]), 64'd1);
    check("starve_clear", 64'(st_log[13]), 64'd0);

    // simultaneous push and pop at level 2
    step(1'b1, 19'd9, 1'b1, 19'd400, 6'd11);
    step(1'b1, 19'd9, 1'b1, 19'd401, 6'd12);
    step(1'b0, 0, 1'b1, 19'd402, 6'd13);
    check("pp_level_before", 64'(o_lvl), 64'd2);
    step(1'b0, 0, 1'b0, 0, 0);
    check("pp_level_after", 64'(o_lvl), 64'd2);
    check("pp_addr0", 64'({o_we, o_addr}), 64'({1'b1, 19'd400}));
    step(1'b0, 0, 1'b0, 0, 0);
    check("pp_addr1", 64'({o_we, o_addr}), 64'({1'b1, 19'd401}));
    step(1'b0, 0, 1'b0, 0, 0);
    check("pp_addr2", 64'({o_we, o_addr, o_lvl}), 64'({1'b1, 19'd402, 3'd0}));
    repeat (3) step(1'b0, 0, 1'b0, 0, 0);

    // reset mid-stream with 3 writes queued and reads in flight
    for (int p = 0; p < 4; p++) step(1'b1, 19'(20 + p), p < 3, 19'(500 + p), 6'(p + 1));
    check("rst_pre_level", 64'(o_lvl), 64'd3);
    disp_req = 1'b0; wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", 64'({mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, disp_rdata, wr_starved}), 64'd0);
    check("rst_ready_level", 64'({wr_ready, fifo_level}), 64'({1'b1, 3'd0}));
    @(posedge clk);
    #1;
    check("rst_hold", 64'({disp_rvalid, mem_en, wr_ready, fifo_level}), 64'({1'b0, 1'b0, 1'b1, 3'd0}));
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 0, 1'b0, 0, 0);
      if (o_rv) rv_seen++;
    end
    check("rst_no_rvalid", 64'(rv_seen), 64'd0);

    // randomized: alternating active-area bursts and blanking gaps
    for (int seg = 0; seg < 12; seg++) begin
      int len;
      int pr;
      len = int'($urandom_range(20, 60));
      pr  = (seg % 2 == 0) ? 85 : 0;
      for (int i = 0; i < len; i++) begin
        step(int'($urandom_range(0, 99)) < pr, 19'($urandom),
             $urandom_range(0, 99) < 60, 19'($urandom), 6'($urandom));
      end
    end
    repeat (10) step(1'b0, 0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
